// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per memoryed handshake, writes the
// register file, emits a difftest commit record and keeps cycle/instret counters.
module wb_stage #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_memoryed_req,
  output logic              o_wb_memoryed_ack,
  input  logic [XLEN-1:0]   i_wb_pc,
  input  logic [31:0]       i_wb_inst,
  input  logic [RIDX_W-1:0] i_wb_rd,
  input  logic              i_wb_rd_wen,
  input  logic [XLEN-1:0]   i_wb_rd_wdata,
  input  logic              i_wb_nocmt,
  input  logic              i_wb_skipcmt,
  input  logic [31:0]       i_wb_intrNo,
  output logic              o_rf_wen,
  output logic [RIDX_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0]   o_rf_wdata,
  output logic              o_cmt_valid,
  output logic [XLEN-1:0]   o_cmt_pc,
  output logic [31:0]       o_cmt_inst,
  output logic              o_cmt_skip,
  output logic [31:0]       o_cmt_intrNo,
  output logic [63:0]       o_cycle_cnt,
  output logic [63:0]       o_instret_cnt,
  output logic              o_wb_writebacked_req,
  input  logic              i_wb_writebacked_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [XLEN-1:0]   pc_r;
  logic [31:0]       inst_r;
  logic [RIDX_W-1:0] rd_r;
  logic              rd_wen_r;
  logic [XLEN-1:0]   rd_wdata_r;
  logic              nocmt_r;
  logic              skipcmt_r;
  logic [31:0]       intr_no_r;
  logic [63:0]       cycle_r;
  logic [63:0]       instret_r;

  logic hs_in_s;
  logic write_s;
  logic done_s;

  assign o_wb_memoryed_ack = (state_r == IDLE);
  assign hs_in_s           = i_wb_memoryed_req & o_wb_memoryed_ack;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; WRITE is always a single cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_in_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: state_nxt_s = DONE;
      DONE: begin
        if (i_wb_writebacked_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Strobes are suppressed in a reset cycle so a dropped transaction leaves no trace.
  always_comb begin
    write_s = 1'b0;
    done_s  = 1'b0;
    if (rst) begin
      write_s = 1'b0;
      done_s  = 1'b0;
    end else begin
      write_s = (state_r == WRITE);
      done_s  = (state_r == DONE);
    end
  end

  // Capture the retiring instruction on the incoming handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= {XLEN{1'b0}};
      inst_r     <= 32'd0;
      rd_r       <= {RIDX_W{1'b0}};
      rd_wen_r   <= 1'b0;
      rd_wdata_r <= {XLEN{1'b0}};
      nocmt_r    <= 1'b0;
      skipcmt_r  <= 1'b0;
      intr_no_r  <= 32'd0;
    end else if (hs_in_s) begin
      pc_r       <= i_wb_pc;
      inst_r     <= i_wb_inst;
      rd_r       <= i_wb_rd;
      rd_wen_r   <= i_wb_rd_wen;
      rd_wdata_r <= i_wb_rd_wdata;
      nocmt_r    <= i_wb_nocmt;
      skipcmt_r  <= i_wb_skipcmt;
      intr_no_r  <= i_wb_intrNo;
    end else begin
      pc_r       <= pc_r;
      inst_r     <= inst_r;
      rd_r       <= rd_r;
      rd_wen_r   <= rd_wen_r;
      rd_wdata_r <= rd_wdata_r;
      nocmt_r    <= nocmt_r;
      skipcmt_r  <= skipcmt_r;
      intr_no_r  <= intr_no_r;
    end
  end

  // Cycle and retired-instruction counters; both wrap naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_r   <= 64'd0;
      instret_r <= 64'd0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (write_s && !nocmt_r) begin
        instret_r <= instret_r + 64'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Register-file write and commit record, driven from the latched instruction.
  always_comb begin
    o_rf_wen     = 1'b0;
    o_cmt_valid  = 1'b0;
    o_cmt_skip   = 1'b0;
    o_cmt_intrNo = 32'd0;
    if (write_s) begin
      o_rf_wen     = rd_wen_r & (rd_r != {RIDX_W{1'b0}});
      o_cmt_valid  = ~nocmt_r;
      o_cmt_skip   = skipcmt_r;
      o_cmt_intrNo = intr_no_r;
    end else begin
      o_rf_wen     = 1'b0;
      o_cmt_valid  = 1'b0;
      o_cmt_skip   = 1'b0;
      o_cmt_intrNo = 32'd0;
    end
  end

  assign o_rf_waddr           = rd_r;
  assign o_rf_wdata           = rd_wdata_r;
  assign o_cmt_pc             = pc_r;
  assign o_cmt_inst           = inst_r;
  assign o_cycle_cnt          = cycle_r;
  assign o_instret_cnt        = instret_r;
  assign o_wb_writebacked_req = done_s;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected write/commit records are queued at
// drive time and popped when the stage reaches its WRITE cycle.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wb_memoryed_req;
  logic        o_wb_memoryed_ack;
  logic [63:0] i_wb_pc;
  logic [31:0] i_wb_inst;
  logic [4:0]  i_wb_rd;
  logic        i_wb_rd_wen;
  logic [63:0] i_wb_rd_wdata;
  logic        i_wb_nocmt;
  logic        i_wb_skipcmt;
  logic [31:0] i_wb_intrNo;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata;
  logic        o_cmt_valid;
  logic [63:0] o_cmt_pc;
  logic [31:0] o_cmt_inst;
  logic        o_cmt_skip;
  logic [31:0] o_cmt_intrNo;
  logic [63:0] o_cycle_cnt;
  logic [63:0] o_instret_cnt;
  logic        o_wb_writebacked_req;
  logic        i_wb_writebacked_ack;

  typedef struct {
    logic        rf_wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
    logic [31:0] intr;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wb_stage #(.XLEN(64), .RIDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_wb_memoryed_req(i_wb_memoryed_req), .o_wb_memoryed_ack(o_wb_memoryed_ack),
    .i_wb_pc(i_wb_pc), .i_wb_inst(i_wb_inst), .i_wb_rd(i_wb_rd),
    .i_wb_rd_wen(i_wb_rd_wen), .i_wb_rd_wdata(i_wb_rd_wdata),
    .i_wb_nocmt(i_wb_nocmt), .i_wb_skipcmt(i_wb_skipcmt), .i_wb_intrNo(i_wb_intrNo),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_cmt_valid(o_cmt_valid), .o_cmt_pc(o_cmt_pc), .o_cmt_inst(o_cmt_inst),
    .o_cmt_skip(o_cmt_skip), .o_cmt_intrNo(o_cmt_intrNo),
    .o_cycle_cnt(o_cycle_cnt), .o_instret_cnt(o_instret_cnt),
    .o_wb_writebacked_req(o_wb_writebacked_req), .i_wb_writebacked_ack(i_wb_writebacked_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive a request (call just after a falling edge) and queue its expected record.
  task automatic drive_req(input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                           input logic wen, input logic [63:0] wdata, input logic nocmt,
                           input logic skip, input logic [31:0] intr);
    rec_t e;
    i_wb_memoryed_req = 1'b1;
    i_wb_pc = pc; i_wb_inst = inst; i_wb_rd = rd; i_wb_rd_wen = wen;
    i_wb_rd_wdata = wdata; i_wb_nocmt = nocmt; i_wb_skipcmt = skip; i_wb_intrNo = intr;
    e.rf_wen = wen && (rd != 5'd0);
    e.waddr = rd; e.wdata = wdata; e.valid = !nocmt;
    e.pc = pc; e.inst = inst; e.skip = skip; e.intr = intr;
    sb.push_back(e);
  endtask

  // Wait (bounded) for writebacked_req, then pulse the ack; ends in IDLE at a falling edge.
  task automatic finish_txn(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_wb_writebacked_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      i_wb_writebacked_ack = 1'b1;
      @(negedge clk);
      i_wb_writebacked_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_wb_memoryed_req = 1'b0; i_wb_writebacked_ack = 1'b0;
    i_wb_pc = 64'd0; i_wb_inst = 32'd0; i_wb_rd = 5'd0; i_wb_rd_wen = 1'b0;
    i_wb_rd_wdata = 64'd0; i_wb_nocmt = 1'b0; i_wb_skipcmt = 1'b0; i_wb_intrNo = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_wb_memoryed_ack !== 1'b1) begin
      errors++; $display("FAIL reset_memoryed_ack got %b want 1", o_wb_memoryed_ack);
    end
    checks++;
    if ({o_rf_wen, o_cmt_valid, o_cmt_skip, o_wb_writebacked_req} !== 4'b0000 ||
        o_rf_waddr !== 5'd0 || o_rf_wdata !== 64'd0 || o_cmt_pc !== 64'd0 ||
        o_cmt_inst !== 32'd0 || o_cmt_intrNo !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got rf_wen=%b cmt_valid=%b wbreq=%b pc=%h want all 0",
                         o_rf_wen, o_cmt_valid, o_wb_writebacked_req, o_cmt_pc);
    end
    checks++;
    if (o_cycle_cnt !== 64'd0 || o_instret_cnt !== 64'd0) begin
      errors++; $display("FAIL reset_counters got cycle=%0d instret=%0d want 0 0", o_cycle_cnt, o_instret_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_cycle_cnt();
    logic [63:0] c0;
    c0 = o_cycle_cnt;
    repeat (7) @(negedge clk);
    checks++;
    if (o_cycle_cnt !== c0 + 64'd7) begin
      errors++; $display("FAIL cycle_cnt got %0d want %0d", o_cycle_cnt, c0 + 64'd7);
    end
  endtask

  task automatic test_single_ld();
    rec_t e;
    bit got;
    logic [63:0] n0;
    n0 = o_instret_cnt;
    drive_req(64'h8000_0000, 32'h0000_3283, 5'd5, 1'b1, 64'h1234, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    i_wb_memoryed_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o_rf_wen !== e.rf_wen || o_rf_waddr !== e.waddr || o_rf_wdata !== e.wdata) begin
      errors++; $display("FAIL ld_rf got wen=%b addr=%0d data=%h want wen=%b addr=%0d data=%h",
                         o_rf_wen, o_rf_waddr, o_rf_wdata, e.rf_wen, e.waddr, e.wdata);
    end
    checks++;
    if (o_cmt_valid !== e.valid || o_cmt_pc !== e.pc || o_cmt_inst !== e.inst) begin
      errors++; $display("FAIL ld_cmt got valid=%b pc=%h inst=%h want valid=%b pc=%h inst=%h",
                         o_cmt_valid, o_cmt_pc, o_cmt_inst, e.valid, e.pc, e.inst);
    end
    checks++;
    if (o_instret_cnt !== n0) begin
      errors++; $display("FAIL ld_instret_early got %0d want %0d", o_instret_cnt, n0);
    end
    @(negedge clk);
    checks++;
    if (o_instret_cnt !== n0 + 64'd1 || o_wb_writebacked_req !== 1'b1 ||
        o_rf_wen !== 1'b0 || o_cmt_valid !== 1'b0) begin
      errors++; $display("FAIL ld_done got instret=%0d wbreq=%b rf_wen=%b cmt=%b want %0d 1 0 0",
                         o_instret_cnt, o_wb_writebacked_req, o_rf_wen, o_cmt_valid, n0 + 64'd1);
    end
    finish_txn(got);
    checks++;
    if (!got || o_wb_memoryed_ack !== 1'b1) begin
      errors++; $display("FAIL ld_finish got wbreq_seen=%b memoryed_ack=%b want 1 1", got, o_wb_memoryed_ack);
    end
  endtask

  task automatic test_x0_write();
    rec_t e;
    bit got;
    logic [63:0] n0;
    n0 = o_instret_cnt;
    drive_req(64'h8000_0004, 32'h0000_0013, 5'd0, 1'b1, 64'hFFFF, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    i_wb_memoryed_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o_rf_wen !== e.rf_wen || o_cmt_valid !== e.valid || o_cmt_pc !== e.pc) begin
      errors++; $display("FAIL x0_write got rf_wen=%b cmt=%b pc=%h want rf_wen=%b cmt=%b pc=%h",
                         o_rf_wen, o_cmt_valid, o_cmt_pc, e.rf_wen, e.valid, e.pc);
    end
    @(negedge clk);
    checks++;
    if (o_instret_cnt !== n0 + 64'd1) begin
      errors++; $display("FAIL x0_instret got %0d want %0d", o_instret_cnt, n0 + 64'd1);
    end
    finish_txn(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL x0_wbreq got 0 want 1");
    end
  endtask

  task automatic test_nocmt();
    rec_t e;
    bit got;
    logic [63:0] n0;
    n0 = o_instret_cnt;
    drive_req(64'h8000_0008, 32'h0030_0193, 5'd3, 1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    i_wb_memoryed_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o_rf_wen !== e.rf_wen || o_rf_waddr !== e.waddr || o_rf_wdata !== e.wdata ||
        o_cmt_valid !== e.valid) begin
      errors++; $display("FAIL nocmt_write got wen=%b addr=%0d data=%h cmt=%b want wen=%b addr=%0d data=%h cmt=%b",
                         o_rf_wen, o_rf_waddr, o_rf_wdata, o_cmt_valid, e.rf_wen, e.waddr, e.wdata, e.valid);
    end
    @(negedge clk);
    checks++;
    if (o_instret_cnt !== n0 || o_wb_writebacked_req !== 1'b1) begin
      errors++; $display("FAIL nocmt_done got instret=%0d wbreq=%b want %0d 1",
                         o_instret_cnt, o_wb_writebacked_req, n0);
    end
    finish_txn(got);
  endtask

  task automatic test_back_to_back();
    rec_t e;
    bit got;
    drive_req(64'h8000_0010, 32'h0000_1111, 5'd7, 1'b1, 64'h0000_0000_0000_0AAA, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (o_rf_wdata !== e.wdata || o_rf_waddr !== e.waddr) begin
      errors++; $display("FAIL bp_first got addr=%0d data=%h want addr=%0d data=%h",
                         o_rf_waddr, o_rf_wdata, e.waddr, e.wdata);
    end
    // Request stays high with the next instruction's data through DONE.
    drive_req(64'h8000_0014, 32'h0000_2222, 5'd9, 1'b1, 64'h0000_0000_0000_0BBB, 1'b0, 1'b0, 32'd0);
    i_wb_writebacked_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_wb_writebacked_req !== 1'b1 || o_wb_memoryed_ack !== 1'b0 || o_rf_wen !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got wbreq=%b memack=%b rf_wen=%b want 1 0 0",
                           i, o_wb_writebacked_req, o_wb_memoryed_ack, o_rf_wen);
      end
    end
    i_wb_writebacked_ack = 1'b1;
    @(negedge clk);
    i_wb_writebacked_ack = 1'b0;
    checks++;
    if (o_wb_memoryed_ack !== 1'b1 || o_wb_writebacked_req !== 1'b0) begin
      errors++; $display("FAIL bp_idle got memack=%b wbreq=%b want 1 0", o_wb_memoryed_ack, o_wb_writebacked_req);
    end
    @(negedge clk);
    i_wb_memoryed_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o_rf_wen !== e.rf_wen || o_rf_waddr !== e.waddr || o_rf_wdata !== e.wdata ||
        o_cmt_valid !== e.valid || o_cmt_pc !== e.pc) begin
      errors++; $display("FAIL bp_second got wen=%b addr=%0d data=%h pc=%h want wen=%b addr=%0d data=%h pc=%h",
                         o_rf_wen, o_rf_waddr, o_rf_wdata, o_cmt_pc, e.rf_wen, e.waddr, e.wdata, e.pc);
    end
    @(negedge clk);
    finish_txn(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL bp_second_wbreq got 0 want 1");
    end
  endtask

  task automatic test_skip_intr();
    rec_t e;
    bit got;
    drive_req(64'h8000_0020, 32'h0000_0073, 5'd10, 1'b0, 64'd0, 1'b0, 1'b1, 32'd7);
    @(negedge clk);
    i_wb_memoryed_req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o_cmt_valid !== e.valid || o_cmt_skip !== e.skip || o_cmt_intrNo !== e.intr ||
        o_rf_wen !== e.rf_wen) begin
      errors++; $display("FAIL skip_write got valid=%b skip=%b intr=%0d rf_wen=%b want %b %b %0d %b",
                         o_cmt_valid, o_cmt_skip, o_cmt_intrNo, o_rf_wen, e.valid, e.skip, e.intr, e.rf_wen);
    end
    @(negedge clk);
    checks++;
    if (o_cmt_skip !== 1'b0 || o_cmt_intrNo !== 32'd0 || o_cmt_valid !== 1'b0) begin
      errors++; $display("FAIL skip_after got skip=%b intr=%0d valid=%b want 0 0 0",
                         o_cmt_skip, o_cmt_intrNo, o_cmt_valid);
    end
    finish_txn(got);
  endtask

  task automatic test_reset_in_write();
    drive_req(64'h8000_0030, 32'h0000_5555, 5'd12, 1'b1, 64'h77, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_wb_memoryed_req = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    checks++;
    if (o_rf_wen !== 1'b0 || o_cmt_valid !== 1'b0) begin
      errors++; $display("FAIL rst_write_strobes got rf_wen=%b cmt=%b want 0 0", o_rf_wen, o_cmt_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_wb_memoryed_ack !== 1'b1 || o_wb_writebacked_req !== 1'b0 ||
        o_cycle_cnt !== 64'd0 || o_instret_cnt !== 64'd0) begin
      errors++; $display("FAIL rst_write_after got memack=%b wbreq=%b cycle=%0d instret=%0d want 1 0 0 0",
                         o_wb_memoryed_ack, o_wb_writebacked_req, o_cycle_cnt, o_instret_cnt);
    end
    @(negedge clk);
    checks++;
    if (o_wb_writebacked_req !== 1'b0 || o_rf_wen !== 1'b0 || o_instret_cnt !== 64'd0) begin
      errors++; $display("FAIL rst_write_dropped got wbreq=%b rf_wen=%b instret=%0d want 0 0 0",
                         o_wb_writebacked_req, o_rf_wen, o_instret_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cycle_cnt();
    test_single_ld();
    test_x0_write();
    test_nocmt();
    test_back_to_back();
    test_skip_intr();
    test_reset_in_write();
    test_single_ld();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
